// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial subtractor: computes (X - Y - B_IN) mod 2^WIDTH, one bit per
// clock, LSB first. It uses a single full-subtractor cell and a borrow
// flip-flop, trading latency for area. A START/BUSY/DONE handshake frames
// each operation. DIFF and B_OUT hold the previous result until the edge
// that raises DONE.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the OVF port, a
// registered two's-complement overflow flag that updates together with DIFF.
//
// Ports
//   CLK    in   clock, rising edge
//   RST_N  in   synchronous active-low reset; takes priority over START
//   START  in   request, sampled only in IDLE
//   X      in   minuend [WIDTH], captured on the accepted START edge
//   Y      in   subtrahend [WIDTH], captured on the accepted START edge
//   B_IN   in   borrow-in, captured on the accepted START edge
//   DIFF   out  registered difference [WIDTH]
//   B_OUT  out  registered borrow-out (1 iff X < Y + B_IN, unsigned)
//   BUSY   out  high during the WIDTH bit-step cycles
//   DONE   out  one-cycle pulse when DIFF/B_OUT are new
//   OVF    out  signed overflow (only with SERIAL_SUB_OVF_EN)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for START; result registers hold
// SHIFT  | one bit-step per cycle, LSB first
// DONE_S | result just published, DONE high for one cycle

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             B_IN,
  output logic [WIDTH-1:0] DIFF,
  output logic             B_OUT,
  output logic             BUSY,
`ifdef SERIAL_SUB_OVF_EN
  output logic             DONE,
  output logic             OVF
`else
  output logic             DONE
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] DONE_S = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;

  logic             bit_x;
  logic             bit_y;
  logic             bit_d;
  logic             bit_b;
  logic [WIDTH-1:0] res_next;
  logic             last_step;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are consumed by the shifters before the final step,
  // so keep copies for the overflow decision.
  logic x_msb_q;
  logic y_msb_q;
`endif

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    bit_x    = x_sr[0];
    bit_y    = y_sr[0];
    bit_d    = bit_x ^ bit_y ^ borrow;
    bit_b    = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & borrow);
    // Written as shift-then-overwrite so WIDTH=1 needs no empty slice.
    res_next = res_sr >> 1;
    res_next[WIDTH-1] = bit_d;
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      x_sr   <= '0;
      y_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      DIFF   <= '0;
      B_OUT  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      x_msb_q <= 1'b0;
      y_msb_q <= 1'b0;
      OVF     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            x_sr   <= X;
            y_sr   <= Y;
            borrow <= B_IN;
            cnt    <= '0;
            res_sr <= '0;
`ifdef SERIAL_SUB_OVF_EN
            x_msb_q <= X[WIDTH-1];
            y_msb_q <= Y[WIDTH-1];
`endif
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          x_sr   <= x_sr >> 1;
          y_sr   <= y_sr >> 1;
          res_sr <= res_next;
          borrow <= bit_b;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            DIFF  <= res_next;
            B_OUT <= bit_b;
`ifdef SERIAL_SUB_OVF_EN
            // The bit produced on the last step is the result sign bit.
            OVF   <= (x_msb_q != y_msb_q) & (bit_d != x_msb_q);
`endif
            state <= DONE_S;
          end
        end

        DONE_S: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY = (state == SHIFT);
  assign DONE = (state == DONE_S);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [3:0] X;
  logic [3:0] Y;
  logic       B_IN;
  logic [3:0] DIFF;
  logic       B_OUT;
  logic       BUSY;
  logic       DONE;
`ifdef SERIAL_SUB_OVF_EN
  logic       OVF;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .X     (X),
    .Y     (Y),
    .B_IN  (B_IN),
    .DIFF  (DIFF),
    .B_OUT (B_OUT),
    .BUSY  (BUSY),
`ifdef SERIAL_SUB_OVF_EN
    .DONE  (DONE),
    .OVF   (OVF)
`else
    .DONE  (DONE)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Called at a negedge with the DUT in IDLE. Accepts one operation, scrambles
  // the inputs and pokes START while busy, checks every cycle through DONE and
  // the return to IDLE. Returns at the negedge after the back-to-IDLE edge.
  task automatic run_op(input string tag,
                        input logic [3:0] x, input logic [3:0] y, input logic b,
                        input logic [3:0] ed, input logic eb, input logic eo,
                        input logic [3:0] pd, input logic pb);
    X = x; Y = y; B_IN = b; START = 1'b1;
    cyc();
    X = ~x; Y = ~y; B_IN = ~b;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_busy"}, {7'd0, BUSY}, 8'd1);
      chk({tag, "_nodone"}, {7'd0, DONE}, 8'd0);
      chk({tag, "_diff_hold"}, {4'd0, DIFF}, {4'd0, pd});
      chk({tag, "_bout_hold"}, {7'd0, B_OUT}, {7'd0, pb});
      START = (k == 3) ? 1'b0 : 1'b1;
      cyc();
    end
    chk({tag, "_done"}, {7'd0, DONE}, 8'd1);
    chk({tag, "_busy_lo"}, {7'd0, BUSY}, 8'd0);
    chk({tag, "_diff"}, {4'd0, DIFF}, {4'd0, ed});
    chk({tag, "_bout"}, {7'd0, B_OUT}, {7'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, {7'd0, OVF}, {7'd0, eo});
`else
    if (eo === 1'bx) $display("note: %s overflow expectation unknown", tag);
`endif
    cyc();
    chk({tag, "_done_lo"}, {7'd0, DONE}, 8'd0);
    chk({tag, "_idle"}, {7'd0, BUSY}, 8'd0);
    chk({tag, "_diff_keep"}, {4'd0, DIFF}, {4'd0, ed});
  endtask

  logic [3:0] hs_diff [3];
  logic       hs_bout [3];

  initial begin
    // Reset with START held high: must not be accepted.
    RST_N = 1'b0; START = 1'b1; X = 4'd9; Y = 4'd3; B_IN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_diff", {4'd0, DIFF}, 8'd0);
    chk("rst_bout", {7'd0, B_OUT}, 8'd0);
    chk("rst_busy", {7'd0, BUSY}, 8'd0);
    chk("rst_done", {7'd0, DONE}, 8'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {7'd0, OVF}, 8'd0);
`endif
    RST_N = 1'b1; START = 1'b0;
    cyc();
    chk("post_rst_idle", {7'd0, BUSY}, 8'd0);

    // Directed operations: 9-3, 3-9, 0-0-1.
    run_op("sub_9_3", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1, 4'h0, 1'b0);
    run_op("sub_3_9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, 4'h6, 1'b0);
    run_op("sub_0_0_b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 4'hA, 1'b1);

    // START held high: accepts at c = 0, 6, 12 with the operands present then.
    hs_diff[0] = 4'h2; hs_bout[0] = 1'b0;   // 3 - 1
    hs_diff[1] = 4'hE; hs_bout[1] = 1'b1;   // 1 - 3
    hs_diff[2] = 4'hA; hs_bout[2] = 1'b0;   // 15 - 5
    START = 1'b1; B_IN = 1'b0;
    for (int c = 0; c < 18; c++) begin
      X = 4'((c * 5 + 3) & 15);
      Y = 4'((c * 3 + 1) & 15);
      cyc();
      chk("hs_busy", {7'd0, BUSY}, ((c % 6) < 4) ? 8'd1 : 8'd0);
      chk("hs_done", {7'd0, DONE}, ((c % 6) == 4) ? 8'd1 : 8'd0);
      if ((c % 6) == 4) begin
        chk("hs_diff", {4'd0, DIFF}, {4'd0, hs_diff[c / 6]});
        chk("hs_bout", {7'd0, B_OUT}, {7'd0, hs_bout[c / 6]});
      end
    end
    START = 1'b0;
    cyc();
    chk("hs_end_idle", {7'd0, BUSY}, 8'd0);

    // Reset two cycles into an operation aborts it.
    X = 4'd9; Y = 4'd3; B_IN = 1'b0; START = 1'b1;
    cyc();
    START = 1'b0;
    cyc();
    RST_N = 1'b0;
    cyc();
    chk("abort_diff", {4'd0, DIFF}, 8'd0);
    chk("abort_bout", {7'd0, B_OUT}, 8'd0);
    chk("abort_busy", {7'd0, BUSY}, 8'd0);
    chk("abort_done", {7'd0, DONE}, 8'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", {7'd0, OVF}, 8'd0);
`endif
    RST_N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("abort_no_done", {7'd0, DONE}, 8'd0);
      chk("abort_no_busy", {7'd0, BUSY}, 8'd0);
    end
    run_op("sub_15_1", 4'd15, 4'd1, 1'b0, 4'hE, 1'b0, 1'b0, 4'h0, 1'b0);

    // Signed-overflow vectors (DIFF/B_OUT checked in every build).
    run_op("sub_7_15", 4'd7, 4'd15, 1'b0, 4'h8, 1'b1, 1'b1, 4'hE, 1'b0);
    run_op("sub_8_1", 4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1, 4'h8, 1'b1);
    run_op("sub_5_2", 4'd5, 4'd2, 1'b0, 4'h3, 1'b0, 1'b0, 4'h7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
